avl_bus_arbiter: RTL and testbench
==================================

# avl_bus_arbiter

Synthesizable N-master to 1-slave arbiter for the Avalon-style bus (address / byte_en / read / write / write_data / request_ready / read_data / read_data_valid / resp_ready). It shares one slave port between MASTER_NUM masters with round-robin request arbitration. Read responses are routed back in order through an internal master-ID FIFO. It sits in front of each shared slave (RAM, peripheral bridge) on the system bus.

## Interface
- MASTER_NUM, 4: number of masters (2..8).
- MAX_OUTSTANDING, 4: read-ID FIFO depth; power of 2, ≥2.
- clk  in  1  system clock, all state on rising edge.
- rest  in  1  asynchronous, active-low reset.
- m_address  in  MASTER_NUM*32  per-master address; master i at [32i+31:32i].
- m_byte_en  in  MASTER_NUM*4  per-master byte enables.
- m_read / m_write  in  MASTER_NUM each  per-master command strobes.
- m_write_data  in  MASTER_NUM*32  per-master write data.
- m_request_ready  out  MASTER_NUM  command accepted this cycle.
- m_read_data  out  32  broadcast copy of s_read_data.
- m_read_data_valid  out  MASTER_NUM  one-hot response valid.
- m_resp_ready  in  MASTER_NUM  per-master response accept.
- s_address, s_byte_en, s_read, s_write, s_write_data  out  32/4/1/1/32  muxed command to slave.
- s_request_ready  in  1  slave accepts command.
- s_read_data  in  32; s_read_data_valid  in  1; s_resp_ready  out  1.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads issued, response not yet accepted.
- err  out  1  sticky protocol-error flag.

## Operation
- Registers: rr_ptr (next priority master), lock_valid + lock_id (held grant), ID FIFO (wr_ptr, rd_ptr, count), err.
- Grant: if lock_valid, grant = lock_id. Otherwise grant = first requesting master (m_read|m_write) scanning rr_ptr, rr_ptr+1, … mod MASTER_NUM. No requester means no grant and all s_ strobes 0.
- Slave command = granted master's address/byte_en/write_data. If that master asserts both read and write: treated as write only, err set.
- Read blocking: if the granted command is a read and count==MAX_OUTSTANDING, s_read=0 and m_request_ready=0. The push is blocked even if a pop happens in the same cycle.
- m_request_ready[grant] = s_request_ready && (s_write || s_read). All other bits are 0.
- Accept cycle (command && s_request_ready) has these effects:
  - rr_ptr ← (grant+1) mod MASTER_NUM.
  - lock_valid ← 0.
  - If the command is a read, push grant into the FIFO.
- Not accepted but granted (slave stall or FIFO full): lock_valid ← 1, lock_id ← grant. The grant stays on the same master until accept, even if higher-priority masters request. If the locked master drops its request before accept: lock released, err set.
- Response routing:
  - head = FIFO[rd_ptr]; m_read_data_valid[head] = s_read_data_valid && count>0.
  - s_resp_ready = m_resp_ready[head] && count>0.
  - Pop when s_read_data_valid && s_resp_ready.
- s_read_data_valid with count==0: response dropped (s_resp_ready=0), err set.
- Simultaneous push and pop (count<MAX): count unchanged, both pointers advance. Pointers wrap mod MAX_OUTSTANDING.
- outstanding = count.

## Timing
- Command path is combinational, zero cycles master→slave. Acceptance completes at the rising edge where request_ready is high.
- Back-to-back accepts by different masters on consecutive cycles are allowed: full throughput, one command per cycle.
- Response path is combinational, zero cycles slave→master.
- Arbitration is fair: with all masters continuously requesting, each is granted once every MASTER_NUM accepts.
- Reset (rest=0, asynchronous) clears rr_ptr=0, lock_valid=0, FIFO pointers/count=0, err=0. While rest=0, all of these are forced 0: s_read, s_write, m_request_ready, m_read_data_valid, s_resp_ready.
- Reset mid-transaction discards all outstanding IDs. Responses arriving after reset set err.
- err clears only on reset.

## Test plan
- Round-robin: all 4 masters write continuously, s_request_ready=1, after reset → grants 0,1,2,3,0 on consecutive cycles; each m_request_ready pulses once per 4 cycles.
- Lock under stall: master 2 writes 0x1000 while s_request_ready=0 for 3 cycles, then master 0 also requests → s_address stays 0x1000 and grant stays 2 until accept; master 0 is granted on the next cycle.
- Ordered routing:
  - Masters 1, 3, 0 each issue one read (addr 0x10, 0x20, 0x30).
  - Slave returns 0xA, 0xB, 0xC with valid in three cycles.
  - Expected: m_read_data_valid = 0010, 1000, 0001 with matching data; outstanding goes 3→0.
- FIFO full: 4 reads outstanding, a 5th read by master 1 → s_read=0, m_request_ready[1]=0. The cycle after one response pops, the 5th read is accepted and outstanding=4.
- Response backpressure: head master holds m_resp_ready=0 for 2 cycles → s_resp_ready=0, count unchanged. Pop occurs on the first cycle ready=1.
- Errors:
  - Response with no outstanding read: err=1.
  - Assert rest=0 mid-burst with 2 outstanding: err=0, outstanding=0, all strobes 0 immediately.

Source files
------------

// File: rtl/avl_bus_arbiter.sv
// avl_bus_arbiter: shares one Avalon-style slave port between MASTER_NUM
// masters. Commands are granted round-robin, and a grant is held while the
// slave stalls. Read responses return in order through a master-ID FIFO.
// Command and response paths are combinational. All state is on clk.
module avl_bus_arbiter #(
  parameter int MASTER_NUM      = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CW  = PW + 1
) (
  input  logic                       clk,
  input  logic                       rest,
  // master side
  input  logic [MASTER_NUM*32-1:0]   m_address,
  input  logic [MASTER_NUM*4-1:0]    m_byte_en,
  input  logic [MASTER_NUM-1:0]      m_read,
  input  logic [MASTER_NUM-1:0]      m_write,
  input  logic [MASTER_NUM*32-1:0]   m_write_data,
  output logic [MASTER_NUM-1:0]      m_request_ready,
  output logic [31:0]                m_read_data,
  output logic [MASTER_NUM-1:0]      m_read_data_valid,
  input  logic [MASTER_NUM-1:0]      m_resp_ready,
  // slave side
  output logic [31:0]                s_address,
  output logic [3:0]                 s_byte_en,
  output logic                       s_read,
  output logic                       s_write,
  output logic [31:0]                s_write_data,
  input  logic                       s_request_ready,
  input  logic [31:0]                s_read_data,
  input  logic                       s_read_data_valid,
  output logic                       s_resp_ready,
  // status
  output logic [CW-1:0]              outstanding,
  output logic                       err
);

  // arbitration state
  logic [IDW-1:0] rr_ptr;
  logic           lock_valid;
  logic [IDW-1:0] lock_id;

  // read-ID FIFO state
  logic [IDW-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // combinational arbitration and command signals
  logic [MASTER_NUM-1:0] req;
  logic                  arb_valid;
  logic [IDW-1:0]        arb_id;
  logic                  grant_valid;
  logic [IDW-1:0]        grant;
  logic                  g_read;
  logic                  g_write;
  logic                  cmd_read;
  logic                  fifo_full;
  logic                  accept;
  logic                  push;

  // combinational response signals
  logic [IDW-1:0] head;
  logic           has_out;
  logic           head_ready;
  logic           pop;

  assign req       = m_read | m_write;
  assign fifo_full = (count == CW'(MAX_OUTSTANDING));
  assign has_out   = (count != '0);
  assign head      = fifo_mem[rd_ptr];

  // Round-robin scan: the first requester at or after rr_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    arb_valid = 1'b0;
    arb_id    = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      if (!arb_valid && req[IDW'((int'(rr_ptr) + k) % MASTER_NUM)]) begin
        arb_valid = 1'b1;
        arb_id    = IDW'((int'(rr_ptr) + k) % MASTER_NUM);
      end
    end
  end

  // A held grant overrides the scan. Mux the granted master's command fields.
  always_comb begin
    grant_valid  = lock_valid | arb_valid;
    grant        = lock_valid ? lock_id : arb_id;
    g_read       = 1'b0;
    g_write      = 1'b0;
    s_address    = '0;
    s_byte_en    = '0;
    s_write_data = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant_valid && grant == IDW'(i)) begin
        g_read       = m_read[i];
        g_write      = m_write[i];
        s_address    = m_address[32*i +: 32];
        s_byte_en    = m_byte_en[4*i +: 4];
        s_write_data = m_write_data[32*i +: 32];
      end
    end
  end

  // A read+write command is issued as a write. A read waits while the ID FIFO is full.
  // Reset forces every strobe low, even though the grant logic still sees requests.
  always_comb begin
    cmd_read        = g_read & ~g_write;
    s_write         = rest & g_write;
    s_read          = rest & cmd_read & ~fifo_full;
    accept          = (s_read | s_write) & s_request_ready;
    push            = accept & s_read;
    m_request_ready = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant == IDW'(i)) m_request_ready[i] = accept;
    end
  end

  // Route the response to the FIFO head. With nothing outstanding, it is dropped.
  always_comb begin
    head_ready        = 1'b0;
    m_read_data_valid = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (head == IDW'(i)) begin
        head_ready           = m_resp_ready[i];
        m_read_data_valid[i] = s_read_data_valid & has_out;
      end
    end
    s_resp_ready = head_ready & has_out;
    pop          = s_read_data_valid & s_resp_ready;
  end

  assign m_read_data = s_read_data;
  assign outstanding = count;

  // Advance priority on accept. Hold the grant on a stall. Release the grant if its master withdraws.
  always_ff @(posedge clk or negedge rest) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rest) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_id    <= '0;
    end else if (accept) begin
      rr_ptr     <= (grant == IDW'(MASTER_NUM - 1)) ? '0 : grant + 1'b1;
      lock_valid <= 1'b0;
    end else if (lock_valid && !(g_read || g_write)) begin
      lock_valid <= 1'b0;
    end else if (grant_valid) begin
      lock_valid <= 1'b1;
      lock_id    <= grant;
    end
  end

  // Read-ID FIFO pointers and occupancy. A push and a pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Store the ID of each accepted read in issue order.
  always_ff @(posedge clk) begin
    // NOTE: ID storage has no reset; an entry is read only after it has been written, and the count guards it.
    if (push) fifo_mem[wr_ptr] <= grant;
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      err <= 1'b0;
    end else if ((lock_valid && !(g_read || g_write)) ||
                 (g_read && g_write) ||
                 (s_read_data_valid && !has_out)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Directed bench for avl_bus_arbiter (4 masters, 4 outstanding reads).
// Inputs change on the falling edge. Outputs are compared 1 ns later, away from the rising edge.
module tb_avl_bus_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rest;
  logic [N*32-1:0] m_address;
  logic [N*4-1:0]  m_byte_en;
  logic [N-1:0]    m_read;
  logic [N-1:0]    m_write;
  logic [N*32-1:0] m_write_data;
  logic [N-1:0]    m_request_ready;
  logic [31:0]     m_read_data;
  logic [N-1:0]    m_read_data_valid;
  logic [N-1:0]    m_resp_ready;
  logic [31:0]     s_address;
  logic [3:0]      s_byte_en;
  logic            s_read;
  logic            s_write;
  logic [31:0]     s_write_data;
  logic            s_request_ready;
  logic [31:0]     s_read_data;
  logic            s_read_data_valid;
  logic            s_resp_ready;
  logic [2:0]      outstanding;
  logic            err;

  int checks = 0;
  int errors = 0;

  avl_bus_arbiter #(.MASTER_NUM(N), .MAX_OUTSTANDING(4)) dut (
    .clk               (clk),
    .rest              (rest),
    .m_address         (m_address),
    .m_byte_en         (m_byte_en),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_write_data      (m_write_data),
    .m_request_ready   (m_request_ready),
    .m_read_data       (m_read_data),
    .m_read_data_valid (m_read_data_valid),
    .m_resp_ready      (m_resp_ready),
    .s_address         (s_address),
    .s_byte_en         (s_byte_en),
    .s_read            (s_read),
    .s_write           (s_write),
    .s_write_data      (s_write_data),
    .s_request_ready   (s_request_ready),
    .s_read_data       (s_read_data),
    .s_read_data_valid (s_read_data_valid),
    .s_resp_ready      (s_resp_ready),
    .outstanding       (outstanding),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit. All stimulus runs a fixed number of cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic set_cmd(input int i, input logic rd, input logic wr, input logic [31:0] addr);
    m_read[i]                = rd;
    m_write[i]               = wr;
    m_address[32*i +: 32]    = addr;
    m_write_data[32*i +: 32] = ~addr;
    m_byte_en[4*i +: 4]      = 4'(i + 1);
  endtask

  task automatic idle_all();
    m_read            = '0;
    m_write           = '0;
    s_read_data_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_all();
    s_request_ready = 1'b0;
    m_resp_ready    = '0;
    rest            = 1'b0;
    @(negedge clk);
    rest = 1'b1;
  endtask

  // While in reset, strobes, ready, valid, count and err must all be zero, even with traffic on the inputs.
  task automatic test_reset();
    @(negedge clk);
    set_cmd(0, 1'b0, 1'b1, 32'h0000_0044);
    s_request_ready   = 1'b1;
    s_read_data_valid = 1'b1;
    m_resp_ready      = '1;
    #1;
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL reset_s_write: got %b want 0", s_write); end
    checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL reset_s_read: got %b want 0", s_read); end
    checks++; if (m_request_ready !== 4'b0000) begin errors++; $display("FAIL reset_mrr: got %b want 0000", m_request_ready); end
    checks++; if (m_read_data_valid !== 4'b0000) begin errors++; $display("FAIL reset_mrdv: got %b want 0000", m_read_data_valid); end
    checks++; if (s_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_s_resp_ready: got %b want 0", s_resp_ready); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    idle_all();
    @(negedge clk);
    rest = 1'b1;
  endtask

  // All four masters write continuously. The grant rotates 0,1,2,3,0,1,2,3.
  task automatic test_round_robin();
    logic [3:0]  exp_mrr;
    logic [31:0] exp_addr;
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 1'b1, 32'h100 * (i + 1));
    s_request_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_mrr  = 4'b0001 << (c % N);
      exp_addr = 32'h100 * ((c % N) + 1);
      checks++; if (m_request_ready !== exp_mrr) begin errors++; $display("FAIL rr_grant c%0d: got %b want %b", c, m_request_ready, exp_mrr); end
      checks++; if (s_address !== exp_addr) begin errors++; $display("FAIL rr_addr c%0d: got %h want %h", c, s_address, exp_addr); end
      checks++; if (s_write_data !== ~exp_addr) begin errors++; $display("FAIL rr_wdata c%0d: got %h want %h", c, s_write_data, ~exp_addr); end
      checks++; if (s_byte_en !== 4'((c % N) + 1)) begin errors++; $display("FAIL rr_byte_en c%0d: got %h want %h", c, s_byte_en, 4'((c % N) + 1)); end
      @(negedge clk);
    end
    idle_all();
  endtask

  // Master 2 stalls and keeps the grant while master 0 also requests. Master 0 is granted after the accept.
  task automatic test_lock_stall();
    apply_reset();
    @(negedge clk);
    set_cmd(2, 1'b0, 1'b1, 32'h1000);
    s_request_ready = 1'b0;
    #1;
    checks++; if (s_address !== 32'h1000 || s_write !== 1'b1) begin errors++; $display("FAIL lock_first: got addr %h wr %b want 1000/1", s_address, s_write); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      set_cmd(0, 1'b0, 1'b1, 32'h2000);
      #1;
      checks++; if (s_address !== 32'h1000) begin errors++; $display("FAIL lock_hold c%0d: got %h want 00001000", c, s_address); end
      checks++; if (m_request_ready !== 4'b0000) begin errors++; $display("FAIL lock_stall_mrr c%0d: got %b want 0000", c, m_request_ready); end
    end
    @(negedge clk);
    s_request_ready = 1'b1;
    #1;
    checks++; if (m_request_ready !== 4'b0100 || s_address !== 32'h1000) begin errors++; $display("FAIL lock_accept: got %b/%h want 0100/00001000", m_request_ready, s_address); end
    @(negedge clk);
    set_cmd(2, 1'b0, 1'b0, 32'h0);
    #1;
    checks++; if (m_request_ready !== 4'b0001 || s_address !== 32'h2000) begin errors++; $display("FAIL lock_next: got %b/%h want 0001/00002000", m_request_ready, s_address); end
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lock_err: got %b want 0", err); end
  endtask

  // Reads from masters 1, 3, 0. Responses come back in that order.
  task automatic test_ordered_routing();
    logic [3:0]  exp_v [3];
    logic [31:0] exp_d [3];
    exp_v = '{4'b0010, 4'b1000, 4'b0001};
    exp_d = '{32'hA, 32'hB, 32'hC};
    apply_reset();
    s_request_ready = 1'b1;
    @(negedge clk);
    set_cmd(1, 1'b1, 1'b0, 32'h10);
    #1;
    checks++; if (s_read !== 1'b1 || m_request_ready !== 4'b0010 || s_address !== 32'h10) begin errors++; $display("FAIL ord_issue1: got rd %b mrr %b addr %h", s_read, m_request_ready, s_address); end
    @(negedge clk);
    idle_all();
    set_cmd(3, 1'b1, 1'b0, 32'h20);
    #1;
    checks++; if (m_request_ready !== 4'b1000 || s_address !== 32'h20) begin errors++; $display("FAIL ord_issue3: got mrr %b addr %h", m_request_ready, s_address); end
    @(negedge clk);
    idle_all();
    set_cmd(0, 1'b1, 1'b0, 32'h30);
    #1;
    checks++; if (m_request_ready !== 4'b0001 || s_address !== 32'h30) begin errors++; $display("FAIL ord_issue0: got mrr %b addr %h", m_request_ready, s_address); end
    m_resp_ready = '1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      idle_all();
      s_read_data_valid = 1'b1;
      s_read_data       = exp_d[r];
      #1;
      checks++; if (outstanding !== 3'(3 - r)) begin errors++; $display("FAIL ord_outstanding r%0d: got %0d want %0d", r, outstanding, 3 - r); end
      checks++; if (m_read_data_valid !== exp_v[r]) begin errors++; $display("FAIL ord_valid r%0d: got %b want %b", r, m_read_data_valid, exp_v[r]); end
      checks++; if (m_read_data !== exp_d[r] || s_resp_ready !== 1'b1) begin errors++; $display("FAIL ord_data r%0d: got %h rdy %b want %h rdy 1", r, m_read_data, s_resp_ready, exp_d[r]); end
    end
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL ord_drained: got %0d want 0", outstanding); end
  endtask

  // With four reads outstanding, a fifth read waits. A pop in the same cycle does not unblock it.
  task automatic test_fifo_full();
    apply_reset();
    s_request_ready = 1'b1;
    m_resp_ready    = '1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      idle_all();
      set_cmd(i, 1'b1, 1'b0, 32'h40 + i);
    end
    @(negedge clk);
    idle_all();
    set_cmd(1, 1'b1, 1'b0, 32'h50);
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", outstanding); end
    checks++; if (s_read !== 1'b0 || m_request_ready !== 4'b0000) begin errors++; $display("FAIL full_block: got rd %b mrr %b want 0/0000", s_read, m_request_ready); end
    @(negedge clk);
    s_read_data_valid = 1'b1;
    s_read_data       = 32'h77;
    #1;
    checks++; if (s_read !== 1'b0 || m_request_ready !== 4'b0000) begin errors++; $display("FAIL full_pop_block: got rd %b mrr %b want 0/0000", s_read, m_request_ready); end
    checks++; if (m_read_data_valid !== 4'b0001) begin errors++; $display("FAIL full_pop_head: got %b want 0001", m_read_data_valid); end
    @(negedge clk);
    s_read_data_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_after_pop: got %0d want 3", outstanding); end
    checks++; if (s_read !== 1'b1 || m_request_ready !== 4'b0010 || s_address !== 32'h50) begin errors++; $display("FAIL full_accept: got rd %b mrr %b addr %h", s_read, m_request_ready, s_address); end
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (outstanding !== 3'd4 || err !== 1'b0) begin errors++; $display("FAIL full_refill: got cnt %0d err %b want 4/0", outstanding, err); end
  endtask

  // The head master holds off its response for two cycles. The pop happens on the first ready cycle.
  task automatic test_resp_backpressure();
    apply_reset();
    s_request_ready = 1'b1;
    @(negedge clk);
    set_cmd(2, 1'b1, 1'b0, 32'h80);
    @(negedge clk);
    idle_all();
    s_read_data_valid = 1'b1;
    s_read_data       = 32'h55;
    m_resp_ready      = 4'b1011;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (s_resp_ready !== 1'b0 || m_read_data_valid !== 4'b0100) begin errors++; $display("FAIL bp_hold c%0d: got rdy %b v %b want 0/0100", c, s_resp_ready, m_read_data_valid); end
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL bp_count c%0d: got %0d want 1", c, outstanding); end
      @(negedge clk);
    end
    m_resp_ready = 4'b1111;
    #1;
    checks++; if (s_resp_ready !== 1'b1 || outstanding !== 3'd1) begin errors++; $display("FAIL bp_release: got rdy %b cnt %0d want 1/1", s_resp_ready, outstanding); end
    @(negedge clk);
    s_read_data_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL bp_popped: got %0d want 0", outstanding); end
  endtask

  // Error cases: a stray response, a read+write command, and a locked master that withdraws its request.
  task automatic test_errors();
    apply_reset();
    m_resp_ready = '1;
    @(negedge clk);
    s_read_data_valid = 1'b1;
    #1;
    checks++; if (s_resp_ready !== 1'b0 || m_read_data_valid !== 4'b0000 || err !== 1'b0) begin errors++; $display("FAIL stray_resp: got rdy %b v %b err %b", s_resp_ready, m_read_data_valid, err); end
    @(negedge clk);
    s_read_data_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_err: got %b want 1", err); end
    @(negedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end

    apply_reset();
    s_request_ready = 1'b1;
    @(negedge clk);
    set_cmd(0, 1'b1, 1'b1, 32'h90);
    #1;
    checks++; if (s_write !== 1'b1 || s_read !== 1'b0 || m_request_ready !== 4'b0001) begin errors++; $display("FAIL rw_cmd: got wr %b rd %b mrr %b", s_write, s_read, m_request_ready); end
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (err !== 1'b1 || outstanding !== 3'd0) begin errors++; $display("FAIL rw_err: got err %b cnt %0d want 1/0", err, outstanding); end

    apply_reset();
    s_request_ready = 1'b0;
    @(negedge clk);
    set_cmd(2, 1'b0, 1'b1, 32'hA0);
    @(negedge clk);
    idle_all();
    set_cmd(1, 1'b0, 1'b1, 32'hB0);
    s_request_ready = 1'b1;
    #1;
    checks++; if (s_write !== 1'b0 || m_request_ready !== 4'b0000 || err !== 1'b0) begin errors++; $display("FAIL drop_lock: got wr %b mrr %b err %b", s_write, m_request_ready, err); end
    @(negedge clk);
    #1;
    checks++; if (err !== 1'b1 || m_request_ready !== 4'b0010) begin errors++; $display("FAIL drop_err: got err %b mrr %b want 1/0010", err, m_request_ready); end
    @(negedge clk);
    idle_all();
  endtask

  // Reset asserted mid-burst with two reads outstanding. A response after reset is flagged.
  task automatic test_reset_mid_burst();
    apply_reset();
    s_request_ready = 1'b1;
    m_resp_ready    = '1;
    @(negedge clk);
    set_cmd(0, 1'b1, 1'b0, 32'hC0);
    @(negedge clk);
    idle_all();
    set_cmd(1, 1'b1, 1'b0, 32'hC4);
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (outstanding !== 3'd2 || err !== 1'b0) begin errors++; $display("FAIL mid_pre: got cnt %0d err %b want 2/0", outstanding, err); end
    @(negedge clk);
    set_cmd(3, 1'b0, 1'b1, 32'hD0);
    s_read_data_valid = 1'b1;
    #1;
    checks++; if (m_read_data_valid !== 4'b0001 || s_write !== 1'b1) begin errors++; $display("FAIL mid_live: got v %b wr %b want 0001/1", m_read_data_valid, s_write); end
    #2;
    rest = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got cnt %0d err %b want 0/0", outstanding, err); end
    checks++; if (s_write !== 1'b0 || s_read !== 1'b0 || m_request_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_cmd: got wr %b rd %b mrr %b", s_write, s_read, m_request_ready); end
    checks++; if (m_read_data_valid !== 4'b0000 || s_resp_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_resp: got v %b rdy %b", m_read_data_valid, s_resp_ready); end
    @(negedge clk);
    rest = 1'b1;
    idle_all();
    s_read_data_valid = 1'b1;
    #1;
    checks++; if (s_resp_ready !== 1'b0) begin errors++; $display("FAIL late_resp_rdy: got %b want 0", s_resp_ready); end
    @(negedge clk);
    s_read_data_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL late_resp_err: got %b want 1", err); end
  endtask

  initial begin
    rest              = 1'b0;
    m_address         = '0;
    m_byte_en         = '0;
    m_read            = '0;
    m_write           = '0;
    m_write_data      = '0;
    m_resp_ready      = '0;
    s_request_ready   = 1'b0;
    s_read_data       = '0;
    s_read_data_valid = 1'b0;

    test_reset();
    test_round_robin();
    test_lock_stall();
    test_ordered_routing();
    test_fifo_full();
    test_resp_backpressure();
    test_errors();
    test_reset_mid_burst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
